// File: rtl/sha_multi_adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sha_pkg
// Shared types and elaboration-time helpers for the SHA multi-operand adder.
//   WORD_W        : native SHA-256 word width
//   word_t        : one SHA word
//   csa_next(n)   : operand count left after one 3:2 compression level
//   csa_levels(n) : depth of the 3:2 tree that reduces n operands to 2
//   csa_count(n,l): operand count present after l tree levels
// -----------------------------------------------------------------------------
package sha_pkg;

   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   // Each full group of three becomes a sum/carry pair; leftovers pass through.
   function automatic int csa_next(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   function automatic int csa_levels(input int n);
      int cnt;
      int lvl;
      cnt = n;
      lvl = 0;
      while (cnt > 2) begin
         cnt = csa_next(cnt);
         lvl = lvl + 1;
      end
      return lvl;
   endfunction

   function automatic int csa_count(input int n, input int lvl);
      int cnt;
      cnt = n;
      for (int i = 0; i < lvl; i++) begin
         cnt = csa_next(cnt);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sha_multi_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// sha_multi_adder_pipe_if
// Valid/ready bundle between a producer of operand beats and the adder.
//   in_valid/in_ready   : input beat handshake
//   ops, op_mask, in_tag: operands (N_OPS x WIDTH), per-operand enable, sideband
//   out_valid/out_ready : result beat handshake
//   sum, out_tag        : modular sum and the tag of the same beat
// Modports: slave = adder side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface sha_multi_adder_pipe_if
   import sha_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int N_OPS = 7,
   parameter int TAG_W = 4
);

   logic                   in_valid;
   logic                   in_ready;
   logic [N_OPS*WIDTH-1:0] ops;
   logic [N_OPS-1:0]       op_mask;
   logic [TAG_W-1:0]       in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       sum;
   logic [TAG_W-1:0]       out_tag;

   modport slave (
      input  in_valid, ops, op_mask, in_tag, out_ready,
      output in_ready, out_valid, sum, out_tag
   );

   modport master (
      output in_valid, ops, op_mask, in_tag, out_ready,
      input  in_ready, out_valid, sum, out_tag
   );

endinterface

// File: rtl/sha_multi_adder_pipe_csa.sv
// -----------------------------------------------------------------------------
// sha_csa3to2
// Combinational 3:2 carry-save compressor, WIDTH bits, modular.
//   a_i, b_i, c_i : three addends
//   s_o           : bitwise sum  a ^ b ^ c
//   cy_o          : majority shifted left by one; the majority MSB is dropped
//                   because it would land at weight 2^WIDTH
// -----------------------------------------------------------------------------
module sha_csa3to2
   import sha_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] s_o,
   output logic [WIDTH-1:0] cy_o
);

   logic [WIDTH-2:0] maj_s;

   assign s_o   = a_i ^ b_i ^ c_i;
   assign maj_s = (a_i[WIDTH-2:0] & b_i[WIDTH-2:0])
                | (a_i[WIDTH-2:0] & c_i[WIDTH-2:0])
                | (b_i[WIDTH-2:0] & c_i[WIDTH-2:0]);
   assign cy_o  = {maj_s, 1'b0};

endmodule

// File: rtl/sha_multi_adder_pipe.sv
// -----------------------------------------------------------------------------
// sha_multi_adder_pipe
// Pipelined multi-operand modular adder used for the SHA round sums.
// Masked operands are reduced by a generated 3:2 carry-save tree and a final
// carry-propagate add; results leave in order with their tag.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears every stage valid and outputs
//   bus : slave side of sha_multi_adder_pipe_if (valid/ready in and out)
// Stage layout (s0 nearest the input, last stage drives the outputs):
//   STAGES=1 : result register
//   STAGES=2 : carry-save pair register, result register
//   STAGES=3 : tree-midpoint register, carry-save pair register, result register
// -----------------------------------------------------------------------------
module sha_multi_adder_pipe
   import sha_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int N_OPS  = 7,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   sha_multi_adder_pipe_if.slave bus
);

   localparam int L   = csa_levels(N_OPS);
   localparam int MID = (L + 1) / 2;

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] load_s, vin_s, en_s;
   logic              adv_s;
   logic [TAG_W-1:0]  tag_q [STAGES];
   logic [TAG_W-1:0]  tag_d [STAGES];
   logic [WIDTH-1:0]  cpa_s, sum_d, sum_q;

   // Ready chain from the output backwards: a stage loads when empty or when
   // the stage after it is loading, so bubbles are squeezed out.
   always_comb begin
      adv_s  = bus.out_ready;
      load_s = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load_s[k] = !v_q[k] || adv_s;
         adv_s     = load_s[k];
      end
   end

   // Next-state of the valid bits and tags; data registers only capture real
   // beats, so an empty stage keeps its old contents.
   always_comb begin
      vin_s    = '0;
      vin_s[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         vin_s[k] = v_q[k-1];
      end
      en_s = load_s & vin_s;
      v_d  = v_q;
      for (int k = 0; k < STAGES; k++) begin
         v_d[k] = load_s[k] ? vin_s[k] : v_q[k];
      end
      tag_d    = tag_q;
      tag_d[0] = en_s[0] ? bus.in_tag : tag_q[0];
      for (int k = 1; k < STAGES; k++) begin
         tag_d[k] = en_s[k] ? tag_q[k-1] : tag_q[k];
      end
   end

   // Valid and tag pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         tag_q <= '{default: '0};
      end else begin
         v_q   <= v_d;
         tag_q <= tag_d;
      end
   end

   // Carry-save tree. Level 0 is the masked operand set; level l compresses
   // level l-1. With three stages the midpoint level is registered in place.
   for (genvar l = 0; l <= L; l++) begin : g_lvl
      localparam int NO = csa_count(N_OPS, l);
      logic [WIDTH-1:0] c_s [NO];
      logic [WIDTH-1:0] o_s [NO];

      if (l == 0) begin : g_mask
         for (genvar i = 0; i < N_OPS; i++) begin : g_op
            assign c_s[i] = bus.ops[i*WIDTH +: WIDTH] & {WIDTH{bus.op_mask[i]}};
         end
      end else begin : g_cmp
         localparam int NI = csa_count(N_OPS, l - 1);
         localparam int NG = NI / 3;
         for (genvar g = 0; g < NG; g++) begin : g_csa
            sha_csa3to2 #(.WIDTH(WIDTH)) u_csa (
               .a_i  (g_lvl[l-1].o_s[3*g]),
               .b_i  (g_lvl[l-1].o_s[3*g+1]),
               .c_i  (g_lvl[l-1].o_s[3*g+2]),
               .s_o  (c_s[2*g]),
               .cy_o (c_s[2*g+1])
            );
         end
         for (genvar r = 0; r < NI % 3; r++) begin : g_pass
            assign c_s[2*NG+r] = g_lvl[l-1].o_s[3*NG+r];
         end
      end

      if (STAGES == 3 && l == MID) begin : g_mid
         logic [WIDTH-1:0] mid_q [NO];
         // Tree-midpoint register, first stage of the three-stage pipe.
         always_ff @(posedge clk) begin
            if (rst) begin
               mid_q <= '{default: '0};
            end else if (en_s[0]) begin
               mid_q <= c_s;
            end
         end
         assign o_s = mid_q;
      end else begin : g_wire
         assign o_s = c_s;
      end
   end

   if (STAGES >= 2) begin : g_pair
      logic [WIDTH-1:0] pa_q, pb_q;
      // Carry-save pair register at the tree output.
      always_ff @(posedge clk) begin
         if (rst) begin
            pa_q <= '0;
            pb_q <= '0;
         end else if (en_s[STAGES-2]) begin
            pa_q <= g_lvl[L].o_s[0];
            pb_q <= g_lvl[L].o_s[1];
         end
      end
      assign cpa_s = pa_q + pb_q;
   end else begin : g_nopair
      assign cpa_s = g_lvl[L].o_s[0] + g_lvl[L].o_s[1];
   end

   // Result next-state: capture the carry-propagate sum of an arriving beat.
   always_comb begin
      sum_d = en_s[STAGES-1] ? cpa_s : sum_q;
   end

   // Result register driving the output bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign bus.in_ready  = load_s[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = sum_q;
   assign bus.out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_sha_multi_adder_pipe.sv
module tb_sha_multi_adder_pipe;
   import sha_pkg::*;

   localparam int W  = 32;
   localparam int N  = 7;
   localparam int TW = 4;

   typedef struct packed {
      logic [W-1:0]  s;
      logic [TW-1:0] t;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [2:0]     in_valid_v;
   logic           out_ready;
   logic [N*W-1:0] ops;
   logic [N-1:0]   op_mask;
   logic [TW-1:0]  in_tag;
   logic [2:0]     in_ready;
   logic [2:0]     out_valid;
   word_t          sum_o     [3];
   logic [TW-1:0]  out_tag_o [3];

   int   errors = 0;
   int   checks = 0;
   exp_t sb [3][$];
   int   emitted  [3];
   logic hold_v   [3];
   word_t         held_sum [3];
   logic [TW-1:0] held_tag [3];

   // Three DUTs, STAGES = 1, 2, 3, sharing operands and out_ready.
   for (genvar d = 0; d < 3; d++) begin : g_dut
      sha_multi_adder_pipe_if #(.WIDTH(W), .N_OPS(N), .TAG_W(TW)) bus ();
      assign bus.in_valid  = in_valid_v[d];
      assign bus.ops       = ops;
      assign bus.op_mask   = op_mask;
      assign bus.in_tag    = in_tag;
      assign bus.out_ready = out_ready;
      assign in_ready[d]   = bus.in_ready;
      assign out_valid[d]  = bus.out_valid;
      assign sum_o[d]      = bus.sum;
      assign out_tag_o[d]  = bus.out_tag;
      sha_multi_adder_pipe #(.WIDTH(W), .N_OPS(N), .STAGES(d + 1), .TAG_W(TW)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   function automatic word_t model_sum(input logic [N*W-1:0] o, input logic [N-1:0] m);
      word_t acc;
      acc = '0;
      for (int i = 0; i < N; i++) begin
         if (m[i]) acc = acc + o[i*W +: W];
      end
      return acc;
   endfunction

   // One clock: settle, score handshakes seen at this edge, move to next negedge.
   task automatic cycle();
      exp_t e;
      #1;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            sb[d].delete();
         end else begin
            if (hold_v[d]) begin
               checks++;
               if (out_valid[d] !== 1'b1 || sum_o[d] !== held_sum[d] || out_tag_o[d] !== held_tag[d])
                  begin
                  errors++;
                  $display("FAIL stall_hold dut%0d: got v=%b sum=%h tag=%h, need v=1 sum=%h tag=%h",
                           d, out_valid[d], sum_o[d], out_tag_o[d], held_sum[d], held_tag[d]);
               end
            end
            if (out_valid[d] && out_ready) begin
               checks++;
               emitted[d]++;
               if (sb[d].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat dut%0d: got sum=%h tag=%h, need no beat",
                           d, sum_o[d], out_tag_o[d]);
               end else begin
                  e = sb[d].pop_front();
                  if (sum_o[d] !== e.s || out_tag_o[d] !== e.t) begin
                     errors++;
                     $display("FAIL scoreboard dut%0d: got sum=%h tag=%h, need sum=%h tag=%h",
                              d, sum_o[d], out_tag_o[d], e.s, e.t);
                  end
               end
            end
            if (in_valid_v[d] && in_ready[d])
               sb[d].push_back(exp_t'{s: model_sum(ops, op_mask), t: in_tag});
         end
         hold_v[d]   = !rst && out_valid[d] && !out_ready;
         held_sum[d] = sum_o[d];
         held_tag[d] = out_tag_o[d];
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid_v = 3'b111; out_ready = 1'b1;
      ops = '1; op_mask = 7'h7F; in_tag = 4'hF;
      cycle();
      cycle();
      rst = 1'b0; in_valid_v = 3'b000;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (out_valid[d] !== 1'b0) begin
            errors++; $display("FAIL reset_valid dut%0d: got %b need 0", d, out_valid[d]);
         end
         checks++;
         if (sum_o[d] !== 32'h0) begin
            errors++; $display("FAIL reset_sum dut%0d: got %h need 0", d, sum_o[d]);
         end
         checks++;
         if (out_tag_o[d] !== 4'h0) begin
            errors++; $display("FAIL reset_tag dut%0d: got %h need 0", d, out_tag_o[d]);
         end
         checks++;
         if (in_ready[d] !== 1'b1) begin
            errors++; $display("FAIL reset_ready dut%0d: got %b need 1", d, in_ready[d]);
         end
      end
   endtask

   task automatic test_wraparound();
      ops = '1; op_mask = 7'h7F; in_tag = 4'd3; out_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         in_valid_v = (j == 0) ? 3'b111 : 3'b000;
         #1;
         if (j >= 1) begin
            for (int d = 0; d < 3; d++) begin
               checks++;
               if (out_valid[d] !== 1'(j == d + 1)) begin
                  errors++;
                  $display("FAIL wrap_latency dut%0d cyc%0d: got v=%b need %b", d, j, out_valid[d], j == d + 1);
               end
               if (j == d + 1) begin
                  checks++;
                  if (sum_o[d] !== 32'hFFFF_FFF9 || out_tag_o[d] !== 4'd3) begin
                     errors++;
                     $display("FAIL wrap_sum dut%0d: got %h/%h need fffffff9/3", d, sum_o[d], out_tag_o[d]);
                  end
               end
            end
         end
         cycle();
      end
   endtask

   task automatic test_masking();
      ops = '0;
      for (int i = 0; i < N; i++) ops[i*W +: W] = 32'(i + 1);
      out_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         in_valid_v = (j < 2) ? 3'b111 : 3'b000;
         op_mask    = (j == 0) ? 7'b0000101 : 7'b0000000;
         in_tag     = (j == 0) ? 4'd5 : 4'd6;
         #1;
         if (j >= 1) begin
            for (int d = 0; d < 3; d++) begin
               checks++;
               if (out_valid[d] !== 1'(j == d + 1 || j == d + 2)) begin
                  errors++;
                  $display("FAIL mask_valid dut%0d cyc%0d: got %b", d, j, out_valid[d]);
               end
               if (j == d + 1) begin
                  checks++;
                  if (sum_o[d] !== 32'h4 || out_tag_o[d] !== 4'd5) begin
                     errors++;
                     $display("FAIL mask_partial dut%0d: got %h/%h need 4/5", d, sum_o[d], out_tag_o[d]);
                  end
               end
               if (j == d + 2) begin
                  checks++;
                  if (sum_o[d] !== 32'h0 || out_tag_o[d] !== 4'd6) begin
                     errors++;
                     $display("FAIL mask_zero dut%0d: got %h/%h need 0/6", d, sum_o[d], out_tag_o[d]);
                  end
               end
            end
         end
         cycle();
      end
   endtask

   task automatic test_backpressure();
      for (int d = 0; d < 3; d++) begin
         int n;
         int base;
         n = 0;
         base = emitted[d];
         ops = '0; op_mask = 7'h7F;
         for (int c = 0; c < 40 && (n < 6 || sb[d].size() != 0); c++) begin
            out_ready = (c >= 5);
            in_valid_v = (n < 6) ? 3'(3'b001 << d) : 3'b000;
            ops[W-1:0] = 32'(n);
            in_tag = 4'(n);
            #1;
            if (c < 5) begin
               checks++;
               if (in_ready[d] !== 1'(n < d + 1)) begin
                  errors++;
                  $display("FAIL bp_ready dut%0d cyc%0d: got %b need %b", d, c, in_ready[d], n < d + 1);
               end
            end
            if (in_valid_v[d] && in_ready[d]) n++;
            cycle();
         end
         in_valid_v = 3'b000;
         checks++;
         if (emitted[d] - base != 6 || sb[d].size() != 0) begin
            errors++;
            $display("FAIL bp_count dut%0d: got %0d emitted, %0d pending, need 6 and 0",
                     d, emitted[d] - base, sb[d].size());
         end
      end
   endtask

   task automatic test_bubble();
      int n;
      n = 0;
      ops = '0; op_mask = 7'h7F;
      for (int j = 0; j < 30 && !(n == 4 && sb[2].size() == 0); j++) begin
         out_ready  = (j >= 6);
         in_valid_v = ((j == 0 || j >= 3) && n < 4) ? 3'b100 : 3'b000;
         ops[W-1:0] = 32'(10 + n);
         in_tag     = 4'(n);
         #1;
         if (j == 0 || j == 3 || j == 4) begin
            checks++;
            if (in_ready[2] !== 1'b1) begin
               errors++; $display("FAIL bubble_ready cyc%0d: got %b need 1", j, in_ready[2]);
            end
         end
         if (j == 5) begin
            checks++;
            if (in_ready[2] !== 1'b0) begin
               errors++; $display("FAIL bubble_full: got %b need 0", in_ready[2]);
            end
         end
         if (in_valid_v[2] && in_ready[2]) n++;
         cycle();
      end
      in_valid_v = 3'b000;
      checks++;
      if (n != 4 || sb[2].size() != 0) begin
         errors++; $display("FAIL bubble_drain: got %0d accepted %0d pending, need 4 and 0", n, sb[2].size());
      end
   endtask

   task automatic test_midflight_reset();
      out_ready = 1'b0; op_mask = 7'h7F;
      ops = '1; in_tag = 4'd1; in_valid_v = 3'b111;
      cycle();
      ops = '0; ops[W-1:0] = 32'h55; in_tag = 4'd2;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) ops[i*W +: W] = 32'(i + 1) << 28;
      in_tag = 4'd9;
      for (int j = 0; j < 5; j++) begin
         in_valid_v = (j == 0) ? 3'b111 : 3'b000;
         #1;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (out_valid[d] !== 1'(j == d + 1)) begin
               errors++;
               $display("FAIL midrst_latency dut%0d cyc%0d: got v=%b need %b", d, j, out_valid[d], j == d + 1);
            end
            if (j == d + 1) begin
               checks++;
               if (sum_o[d] !== 32'hC000_0000 || out_tag_o[d] !== 4'd9) begin
                  errors++;
                  $display("FAIL midrst_sum dut%0d: got %h/%h need c0000000/9", d, sum_o[d], out_tag_o[d]);
               end
            end
         end
         cycle();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         in_valid_v = 3'($urandom);
         out_ready  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) ops[i*W +: W] = $urandom();
         op_mask = 7'($urandom);
         in_tag  = 4'($urandom);
         cycle();
      end
      in_valid_v = 3'b000;
      out_ready  = 1'b1;
      for (int c = 0; c < 20; c++) cycle();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sb[d].size() != 0) begin
            errors++; $display("FAIL random_drain dut%0d: got %0d pending need 0", d, sb[d].size());
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         emitted[d] = 0;
         hold_v[d]  = 1'b0;
      end
      test_reset();
      test_wraparound();
      test_masking();
      test_backpressure();
      test_bubble();
      test_midflight_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
